// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: state encoding, port ids and funct3 access masks
// shared by the arbiter, the core and data_mem.
package dmem_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    LOCK1 = 1'b1
  } arb_state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  typedef struct packed {
    logic pend;
    logic port;
  } rd_tag_t;

  typedef struct packed {
    logic        wen;
    logic [2:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic is_read(mem_req_t r);
    return !r.wen;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request/grant/read-return bundle of both
// requester ports; master = requesters, slave = arbiter.
interface dmem_arbiter_if;

  logic        req0_i;
  logic        req1_i;
  logic        wen0_i;
  logic        wen1_i;
  logic [2:0]  mask0_i;
  logic [2:0]  mask1_i;
  logic [31:0] addr0_i;
  logic [31:0] addr1_i;
  logic [31:0] wdata0_i;
  logic [31:0] wdata1_i;
  logic        lock1_i;
  logic        gnt0_o;
  logic        gnt1_o;
  logic        rvalid0_o;
  logic        rvalid1_o;
  logic [31:0] rdata0_o;
  logic [31:0] rdata1_o;

  modport master (
    output req0_i, req1_i,
    output wen0_i, wen1_i,
    output mask0_i, mask1_i,
    output addr0_i, addr1_i,
    output wdata0_i, wdata1_i,
    output lock1_i,
    input  gnt0_o, gnt1_o,
    input  rvalid0_o, rvalid1_o,
    input  rdata0_o, rdata1_o
  );

  modport slave (
    input  req0_i, req1_i,
    input  wen0_i, wen1_i,
    input  mask0_i, mask1_i,
    input  addr0_i, addr1_i,
    input  wdata0_i, wdata1_i,
    input  lock1_i,
    output gnt0_o, gnt1_o,
    output rvalid0_o, rvalid1_o,
    output rdata0_o, rdata1_o
  );

endinterface

// File: rtl/dmem_arbiter_lock_timer.sv
// dmem_arbiter_lock_timer: saturating port-1 lock counter; flags
// when the next step would reach MAX_LOCK (forced release).
module dmem_arbiter_lock_timer #(
  parameter int MAX_LOCK = 16
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic start,
  input  logic run,
  input  logic clr,
  output logic expire_start,
  output logic expire_run
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_LOCK);

  logic [CW-1:0] count;
  logic [CW-1:0] count_inc;
  logic [CW-1:0] count_nxt;

  assign count_inc = (count == LIMIT) ? LIMIT
                   : count + CW'(1);

  // A fresh lock already counts one cycle of ownership.
  assign expire_start = (LIMIT == CW'(1));
  assign expire_run   = (count_inc == LIMIT);

  // Load, advance or clear the counter
  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      start:   count_nxt = CW'(1);
      run:     count_nxt = count_inc;
      clr:     count_nxt = '0;
      default: ;
    endcase
  end

  // Counter register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares data_mem between core (port 0) and a second
// master (port 1). Macro ARB_ROUND_ROBIN_EN selects round-robin.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_LOCK = 16
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  dmem_arbiter_if.slave bus,
  output logic          mem_wen_o,
  output logic [2:0]    mem_mask_o,
  output logic [31:0]   mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  arb_state_e state;
  arb_state_e state_nxt;
  rd_tag_t    tag;
  rd_tag_t    tag_nxt;
  mem_req_t   p0;
  mem_req_t   p1;
  mem_req_t   mreq;

  logic req0;
  logic req1;
  logic g0;
  logic g1;
  logic prefer1;
  logic t_start;
  logic t_run;
  logic t_clr;
  logic exp_start;
  logic exp_run;
  logic force_rel;
  logic bar;
  logic bar_nxt;
  logic rv0;
  logic rv1;

  // Requests are ignored while reset is held so nothing is granted.
  assign req0 = bus.req0_i & reset_ni;
  assign req1 = bus.req1_i & reset_ni;

  assign p0 = {bus.wen0_i, bus.mask0_i,
               bus.addr0_i, bus.wdata0_i};
  assign p1 = {bus.wen1_i, bus.mask1_i,
               bus.addr1_i, bus.wdata1_i};

`ifdef ARB_ROUND_ROBIN_EN
  logic last;
  logic last_nxt;
  logic prio0;
  logic prio0_nxt;

  // After a forced release port 0 wins once regardless of pointer.
  assign prefer1 = !prio0 && (last == PORT0);

  // Pointer and post-release priority next values
  always_comb begin
    last_nxt  = last;
    prio0_nxt = prio0;
    if (g0) begin
      last_nxt = PORT0;
    end else if (g1) begin
      last_nxt = PORT1;
    end
    if (force_rel) begin
      prio0_nxt = 1'b1;
    end else if (state == IDLE && req0 && req1) begin
      prio0_nxt = 1'b0;
    end
  end

  // Round-robin registers; port 0 is favoured out of reset
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last  <= PORT1;
      prio0 <= 1'b0;
    end else begin
      last  <= last_nxt;
      prio0 <= prio0_nxt;
    end
  end
`else
  assign prefer1 = 1'b0;
`endif

  dmem_arbiter_lock_timer #(
    .MAX_LOCK (MAX_LOCK)
  ) u_lock_timer (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .start        (t_start),
    .run          (t_run),
    .clr          (t_clr),
    .expire_start (exp_start),
    .expire_run   (exp_run)
  );

  // Grant choice, lock entry/exit and re-lock barrier
  always_comb begin
    state_nxt = state;
    g0        = 1'b0;
    g1        = 1'b0;
    t_start   = 1'b0;
    t_run     = 1'b0;
    t_clr     = 1'b0;
    force_rel = 1'b0;
    unique case (state)
      IDLE: begin
        g1 = req1 && (!req0 || prefer1);
        g0 = req0 && !g1;
        if (g1 && bus.lock1_i && !bar) begin
          t_start = 1'b1;
          if (exp_start) begin
            force_rel = 1'b1;
          end else begin
            state_nxt = LOCK1;
          end
        end else begin
          t_clr = 1'b1;
        end
      end
      LOCK1: begin
        g1 = req1;
        if (!bus.lock1_i) begin
          state_nxt = IDLE;
          t_clr     = 1'b1;
        end else begin
          t_run = 1'b1;
          if (exp_run) begin
            force_rel = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Barrier lifts after one cycle without a port-1 grant.
    bar_nxt = force_rel || (bar && g1);
  end

  // Memory-side mux and read tag for the granted port
  always_comb begin
    mreq    = '0;
    tag_nxt = '0;
    unique case (1'b1)
      g0:      mreq = p0;
      g1:      mreq = p1;
      default: ;
    endcase
    tag_nxt.pend = (g0 || g1) && is_read(mreq);
    tag_nxt.port = g1 ? PORT1 : PORT0;
  end

  // FSM state, read tag and re-lock barrier
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= IDLE;
      tag   <= '0;
      bar   <= 1'b0;
    end else begin
      state <= state_nxt;
      tag   <= tag_nxt;
      bar   <= bar_nxt;
    end
  end

  assign {mem_wen_o, mem_mask_o,
          mem_addr_o, mem_wdata_o} = mreq;

  assign rv0 = tag.pend && (tag.port == PORT0);
  assign rv1 = tag.pend && (tag.port == PORT1);

  assign bus.gnt0_o    = g0;
  assign bus.gnt1_o    = g1;
  assign bus.rvalid0_o = rv0;
  assign bus.rvalid1_o = rv1;
  assign bus.rdata0_o  = rv0 ? mem_rdata_i : '0;
  assign bus.rdata1_o  = rv1 ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed + random stimulus, rule-level model,
// read-return scoreboard checked by an independent monitor.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MAX_LOCK = 4;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        mem_init = 1'b1;
  logic        mem_wen;
  logic [2:0]  mem_mask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] dmem [16];

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .bus         (bus),
    .mem_wen_o   (mem_wen),
    .mem_mask_o  (mem_mask),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  function automatic logic [31:0] init_val(int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  // data_mem stand-in: word-wide, one-cycle read latency
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) dmem[i] <= init_val(i);
    end else if (mem_wen) begin
      dmem[mem_addr[5:2]] <= mem_wdata;
    end
    mem_rdata <= dmem[mem_addr[5:2]];
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(string name, logic [71:0] act,
                     logic [71:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // requester-side transaction state
  bit          t_req [2];
  bit          t_wen [2];
  logic [2:0]  t_mask [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wdata [2];
  bit          t_lock1;

  // reference model state
  logic [31:0] ref_mem [16];
  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];
  bit m_locked, m_p0first, m_barred;
  int m_len, m_last;

  function automatic void model_reset();
    m_locked = 0; m_p0first = 0; m_barred = 0;
    m_len = 0; m_last = 1;
  endfunction

  task automatic new_txn(int i, bit wen, logic [31:0] a,
                         logic [31:0] d);
    logic [2:0] masks [5];
    masks = '{MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU};
    t_req[i] = 1; t_wen[i] = wen; t_addr[i] = a;
    t_wdata[i] = d; t_mask[i] = masks[$urandom_range(0, 4)];
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [3:0] w = 4'($urandom_range(0, 15));
    return {26'b0, w, 2'b00};
  endfunction

  // one clock: drive, predict, compare, advance model
  task automatic cycle();
    bit g0, g1, setb;
    logic [67:0] eb;
    @(negedge clk);
    bus.req0_i = t_req[0];   bus.req1_i = t_req[1];
    bus.wen0_i = t_wen[0];   bus.wen1_i = t_wen[1];
    bus.mask0_i = t_mask[0]; bus.mask1_i = t_mask[1];
    bus.addr0_i = t_addr[0]; bus.addr1_i = t_addr[1];
    bus.wdata0_i = t_wdata[0];
    bus.wdata1_i = t_wdata[1];
    bus.lock1_i = t_lock1;
    #1;
    g0 = 0; g1 = 0; setb = 0;
    if (m_locked) begin
      g1 = t_req[1];
      m_len++;
      if (!t_lock1) m_locked = 0;
      else if (m_len >= MAX_LOCK) begin
        m_locked = 0; m_p0first = 1; setb = 1;
      end
    end else begin
      if (t_req[0] && t_req[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (m_p0first || m_last == 1) g0 = 1;
        else g1 = 1;
`else
        g0 = 1;
`endif
        m_p0first = 0;
      end else begin
        g0 = t_req[0]; g1 = t_req[1];
      end
      if (g1 && t_lock1 && !m_barred) begin
        m_len = 1;
        if (m_len >= MAX_LOCK) begin
          m_p0first = 1; setb = 1;
        end else m_locked = 1;
      end
    end
    if (setb) m_barred = 1;
    else if (!g1) m_barred = 0;
    if (g0) m_last = 0;
    if (g1) m_last = 1;
    eb = '0;
    for (int i = 0; i < 2; i++) begin
      if ((i == 0 && g0) || (i == 1 && g1)) begin
        eb = {t_wen[i], t_mask[i], t_addr[i], t_wdata[i]};
        if (t_wen[i]) ref_mem[t_addr[i][5:2]] = t_wdata[i];
        else if (i == 0) exp0.push_back(ref_mem[t_addr[i][5:2]]);
        else exp1.push_back(ref_mem[t_addr[i][5:2]]);
        t_req[i] = 0;
      end
    end
    chk("gnt", {bus.gnt1_o, bus.gnt0_o}, {g1, g0});
    chk("mem_bus", {mem_wen, mem_mask, mem_addr, mem_wdata}, eb);
  endtask

  task automatic drain();
    int n = 0;
    t_lock1 = 0;
    while ((t_req[0] || t_req[1]) && n < 40) begin
      cycle(); n++;
    end
    chk("drain_done", t_req[0] | t_req[1], 0);
  endtask

  // monitor: read returns against the scoreboard queues
  initial forever begin
    @(posedge clk); #1;
    chk("rvalid0", bus.rvalid0_o, exp0.size() > 0);
    chk("rvalid1", bus.rvalid1_o, exp1.size() > 0);
    if (exp0.size() > 0) begin
      if (bus.rvalid0_o) chk("rdata0", bus.rdata0_o, exp0[0]);
      void'(exp0.pop_front());
    end else chk("rdata0_idle", bus.rdata0_o, 0);
    if (exp1.size() > 0) begin
      if (bus.rvalid1_o) chk("rdata1", bus.rdata1_o, exp1[0]);
      void'(exp1.pop_front());
    end else chk("rdata1_idle", bus.rdata1_o, 0);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      t_req[i] = 0; t_wen[i] = 0; t_mask[i] = '0;
      t_addr[i] = '0; t_wdata[i] = '0;
    end
    t_lock1 = 0;
    bus.req0_i = 1; bus.req1_i = 1; bus.wen0_i = 1;
    bus.wen1_i = 1; bus.mask0_i = '0; bus.mask1_i = '0;
    bus.addr0_i = '0; bus.addr1_i = '0;
    bus.wdata0_i = '0; bus.wdata1_i = '0; bus.lock1_i = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    model_reset();
    @(negedge clk); #1;
    chk("reset_ctl", {bus.gnt0_o, bus.gnt1_o, bus.rvalid0_o,
                      bus.rvalid1_o, mem_wen}, 0);
    chk("reset_data", {bus.rdata0_o, bus.rdata1_o}, 0);
    bus.req0_i = 0; bus.req1_i = 0;
    @(negedge clk);
    mem_init = 0; reset_ni = 1;
    cycle();

    // port 0 lone read of 0x10
    new_txn(0, 0, 32'h10, 0);
    cycle(); cycle();

    // both ports reading every cycle
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++)
        if (!t_req[i]) new_txn(i, 0, rnd_addr(), 0);
      cycle();
    end
    drain();

    // port 1 lock against continuous port 0 traffic
    new_txn(1, 0, rnd_addr(), 0);
    t_lock1 = 1;
    cycle();
    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 2; i++)
        if (!t_req[i]) new_txn(i, 0, rnd_addr(), 0);
      cycle();
    end
    drain();

    // port 1 word write, port 0 reads it back
    new_txn(1, 1, 32'h20, 32'hCAFEF00D);
    t_mask[1] = MASK_W;
    cycle();
    new_txn(0, 0, 32'h20, 0);
    cycle(); cycle();

    // reset right after a read grant
    new_txn(0, 0, 32'h10, 0);
    cycle();
    @(posedge clk);
    reset_ni = 0;
    exp0.delete(); exp1.delete();
    model_reset();
    @(negedge clk);
    bus.req0_i = 1; bus.req1_i = 1; bus.wen0_i = 1;
    #1;
    chk("rst_gnt", {bus.gnt1_o, bus.gnt0_o, mem_wen}, 0);
    chk("rst_bus", {mem_mask, mem_addr, mem_wdata}, 0);
    chk("rst_rv", {bus.rvalid0_o, bus.rvalid1_o,
                   bus.rdata0_o, bus.rdata1_o}, 0);
    bus.req0_i = 0; bus.req1_i = 0;
    reset_ni = 1;
    new_txn(0, 0, rnd_addr(), 0);
    new_txn(1, 0, rnd_addr(), 0);
    cycle();
    drain();

    // random traffic
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++)
        if (!t_req[i] && $urandom_range(0, 2) != 0)
          new_txn(i, $urandom_range(0, 2) == 0,
                  rnd_addr(), $urandom);
      t_lock1 = $urandom_range(0, 3) != 0;
      cycle();
    end
    drain();
    cycle(); cycle();
    chk("queues_empty", exp0.size() + exp1.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between the RISC-V core (port 0) and a secondary bus master (port 1, e.g. program loader or debug bridge). It sits between the requesters and `data_mem`, on the divided core clock. Per cycle it grants at most one request, tags each read so the one-cycle-latency read data returns to the right port, and supports a bounded lock so port 1 can do uninterrupted multi-access sequences.

## Interface
Parameters:
- `MAX_LOCK`, 16: max consecutive cycles port 1 may hold a lock before forced release; ≥1.

Ports:
- `clk_i`  in  1  clock (divided core clock)
- `reset_ni`  in  1  reset, asynchronous, active-low
- `req{0,1}_i`  in  1  access request; held until granted
- `wen{0,1}_i`  in  1  write enable (0 = read)
- `mask{0,1}_i`  in  3  access size/sign (funct3 encoding, passed through)
- `addr{0,1}_i`  in  32  byte address
- `wdata{0,1}_i`  in  32  write data
- `lock1_i`  in  1  port 1 requests to keep ownership after the current grant
- `gnt{0,1}_o`  out  1  request accepted this cycle (combinational)
- `rvalid{0,1}_o`  out  1  read data valid on `rdata{n}_o` (registered)
- `rdata{0,1}_o`  out  32  read data; valid only while `rvalid{n}_o`
- `mem_wen_o`  out  1  to `data_mem` write enable
- `mem_mask_o`  out  3  to `data_mem` mask
- `mem_addr_o`  out  32  to `data_mem` address
- `mem_wdata_o`  out  32  to `data_mem` write data
- `mem_rdata_i`  in  32  from `data_mem` read data, one cycle after address

## Operation
- States: `IDLE`, `LOCK1`. Round-robin pointer `last` (1 bit: last granted port).
- IDLE, one requester: that port granted. Both: port ≠ `last` granted (with `ARB_ROUND_ROBIN_EN`).
- Granted port's `wen/mask/addr/wdata` muxed to `mem_*_o` that cycle; `last` updated at edge.
- No grant: `mem_wen_o`=0, `mem_addr_o`=0, `mem_mask_o`=0, `mem_wdata_o`=0.
- Read granted: registered tag `{pending, port}` set; next cycle `rvalid{port}_o`=1, `rdata{port}_o`=`mem_rdata_i`. Other port's `rdata` = 0. Writes produce no `rvalid`.
- Port 1 granted with `lock1_i`=1 → enter `LOCK1`, lock counter = 1. In `LOCK1`, only port 1 can be granted; counter increments each cycle.
- Exit `LOCK1` → IDLE when `lock1_i`=0, or counter reaches `MAX_LOCK` (forced release); after forced release port 0 wins the next contended cycle regardless of pointer, and `lock1_i` is ignored for re-lock until port 1 has been un-granted one cycle.
- Port 1 drops `req1_i` while locked: no grant, lock still held, counter keeps running.

## Timing
- Grant latency 0 cycles (same cycle as `req`); read data latency 1 cycle after grant; back-to-back reads from alternating ports sustain 1 access/cycle.
- Reset (async assert, sync-safe deassert by upstream): state=IDLE, `last`=1 (port 0 favoured first), tag cleared, counter=0, all `rvalid`=0, `rdata`=0; `gnt`/`mem_wen_o` forced 0 while `reset_ni`=0.
- Reset mid-read: pending `rvalid` is dropped, never issued.
- Lock counter saturates at `MAX_LOCK`; no wrap.
- Requests arriving during the `rvalid` cycle are granted normally (tag and new grant overlap).

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: contention resolved by round-robin pointer as above.
- Not defined: fixed priority, port 0 always wins contention in IDLE; `last` register removed; lock and forced-release rules unchanged.

## Structure
- Shared package: state encoding (`IDLE`, `LOCK1`), port index constants, funct3 mask constants (byte/half/word, signed/unsigned) shared with `core` and `data_mem`.
- One sub-module natural: `lock_timer` (saturating counter with `MAX_LOCK` compare and forced-release flag).

## Test plan
- Port 0 reads `0x10` alone, memory holds `0xDEADBEEF` → `gnt0_o`=1 same cycle, next cycle `rvalid0_o`=1, `rdata0_o`=`0xDEADBEEF`, `rvalid1_o`=0.
- Both ports request every cycle for 4 cycles after reset (RR on) → grants 0,1,0,1; each read returned to the matching port one cycle later.
- Same with `ARB_ROUND_ROBIN_EN` undefined → grants 0,0,0,0; `gnt1_o` stays 0.
- Port 1 locks with `MAX_LOCK`=4 while port 0 requests continuously → 4 port-1 grants, forced release, port 0 granted on cycle 5, port 1 not re-locked immediately.
- Port 1 write `0xCAFEF00D` to `0x20` (word mask), then port 0 reads `0x20` → `mem_wen_o`=1 once, no `rvalid`; port 0 receives `0xCAFEF00D`.
- Assert `reset_ni`=0 in the cycle after a read grant → no `rvalid`, all outputs 0, after release port 0 wins first contended cycle.
